fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS pipeline: holds the PC, requests instructions from instruction memory over a req/ack handshake, and fills the IF/ID register whose `opcode` field drives the controller. Handles hazard stalls, flushes from branch/bne resolution, and optionally early redirection of `j`/`jal`. Downstream stages see a NOP (all-zero instruction) whenever no valid instruction is presented.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage with an imem req/ack handshake, a stall hold buffer and flush/drop handling.
// Optional macro EARLY_JUMP_EN: decode j/jal in IF/ID and redirect one cycle early.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
);
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pc4, target, buf_instr, buf_pc4;
  logic jump, redir;
  assign opcode = if_id_instr[31:26];
  assign pc4 = pc + 32'd4;
`ifdef EARLY_JUMP_EN
  assign jump = if_id_valid && !stall && (opcode == 6'b000010 || opcode == 6'b000011);
`else
  assign jump = 1'b0;
`endif
  assign redir = flush || jump;
  assign target = flush ? redirect_pc : {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
  // A redirect with an unacked request outstanding must still absorb that ack, hence DROP.
  always_comb begin
    state_n = state;
    pc_n = pc;
    if (redir) begin
      pc_n = target;
      state_n = (imem_req && !imem_ack) ? DROP : FETCH;
    end else begin
      case (state)
        BOOT: state_n = FETCH;
        FETCH: begin
          pc_n = imem_ack ? pc4 : pc;
          state_n = (imem_ack && stall) ? HOLD : FETCH;
        end
        HOLD: state_n = stall ? HOLD : FETCH;
        DROP: state_n = imem_ack ? FETCH : DROP;
        default: state_n = BOOT;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4 <= '0;
      if_id_valid <= 1'b0;
      buf_instr <= '0;
      buf_pc4 <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      imem_req <= (state_n == FETCH) || (state_n == DROP);
      imem_addr <= (state_n == DROP) ? imem_addr : pc_n;
      if (redir || state == DROP || (state == FETCH && !stall && !imem_ack)) begin
        if_id_instr <= '0;
        if_id_pc4 <= '0;
        if_id_valid <= 1'b0;
      end else if (state == FETCH && !stall) begin
        if_id_instr <= imem_rdata;
        if_id_pc4 <= pc4;
        if_id_valid <= 1'b1;
      end else if (state == HOLD && !stall) begin
        if_id_instr <= buf_instr;
        if_id_pc4 <= buf_pc4;
        if_id_valid <= 1'b1;
      end
      if (!redir && state == FETCH && stall && imem_ack) begin
        buf_instr <= imem_rdata;
        buf_pc4 <= pc4;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized checks of fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h40;
`ifdef EARLY_JUMP_EN
  localparam bit EJ = 1'b1;
`else
  localparam bit EJ = 1'b0;
`endif
  logic clk = 0, rst = 1, stall = 0, flush = 0, imem_ack = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc4;
  logic [5:0] opcode;
  int cmp = 0, bad = 0;
  logic jovr = 0;
  logic [31:0] jaddr = 0, jinstr = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .opcode(opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (jovr && a == jaddr) return jinstr;
    return (a[6:2] == 5'd13) ? {5'b00001, a[7], 18'h0, a[15:8]} : {6'b001000, a[27:2]};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Model: next PC, an outstanding discarded request, and a queue of instructions fetched under stall.
  logic [31:0] m_pc, m_old, m_instr, m_pc4;
  logic m_valid, m_boot, m_drop;
  logic [63:0] m_q[$];

  function automatic logic m_req();
    return !m_boot && m_q.size() == 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RPC; m_boot = 1; m_drop = 0; m_q.delete();
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_old = 0;
    end else begin : upd
      logic jmp, ack;
      logic [31:0] tgt, cur;
      jmp = EJ && m_valid && !stall && m_instr[31:27] == 5'b00001;
      tgt = flush ? redirect_pc : {m_pc4[31:28], m_instr[25:0], 2'b00};
      ack = m_req() && imem_ack;
      cur = m_drop ? m_old : m_pc;
      if (flush || jmp) begin
        {m_instr, m_pc4, m_valid} = '0;
        if (m_req()) begin m_drop = !ack; m_old = cur; end else m_drop = 0;
        m_q.delete();
        m_pc = tgt;
        m_boot = 0;
      end else if (m_boot) m_boot = 0;
      else if (m_drop) begin
        if (ack) m_drop = 0;
      end else if (m_q.size() != 0) begin
        if (!stall) begin {m_instr, m_pc4} = m_q.pop_front(); m_valid = 1; end
      end else if (ack) begin
        if (stall) m_q.push_back({mem(cur), m_pc + 32'd4});
        else begin m_instr = mem(cur); m_pc4 = m_pc + 32'd4; m_valid = 1; end
        m_pc = m_pc + 32'd4;
      end else if (!stall) {m_instr, m_pc4, m_valid} = '0;
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("req", imem_req, m_req());
    if (m_req()) chk("addr", imem_addr, m_drop ? m_old : m_pc);
    chk("valid", if_id_valid, m_valid);
    chk("instr", if_id_instr, m_instr);
    chk("pc4", if_id_pc4, m_pc4);
    chk("opcode", opcode, m_instr[31:26]);
  end

  task automatic step(input logic s, input logic f, input logic [31:0] r, input logic a);
    stall = s; flush = f; redirect_pc = r;
    imem_ack = a && imem_req;
    imem_rdata = imem_req ? mem(imem_addr) : 32'hDEAD_BEEF;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_req", imem_req, 0); chk("rst_addr", imem_addr, RPC); chk("rst_valid", if_id_valid, 0);
    chk("rst_instr", if_id_instr, 0); chk("rst_pc4", if_id_pc4, 0);
    rst = 0;
    step(0, 0, 0, 0);
    chk("boot_req", imem_req, 1); chk("boot_addr", imem_addr, 32'h40); chk("boot_valid", if_id_valid, 0);
    step(0, 0, 0, 1); chk("zw_addr1", imem_addr, 32'h44); chk("zw_pc4_1", if_id_pc4, 32'h44); chk("zw_valid1", if_id_valid, 1);
    step(0, 0, 0, 1); chk("zw_addr2", imem_addr, 32'h48); chk("zw_pc4_2", if_id_pc4, 32'h48);
    step(0, 0, 0, 1); chk("zw_pc4_3", if_id_pc4, 32'h4C); chk("zw_instr3", if_id_instr, 32'h2000_0012);
    step(0, 0, 0, 0); chk("slow_nop", if_id_valid, 0); chk("slow_addr", imem_addr, 32'h4C);
    step(0, 0, 0, 0); chk("slow_addr2", imem_addr, 32'h4C);
    step(0, 0, 0, 1); chk("slow_pc4", if_id_pc4, 32'h50);
    step(1, 0, 0, 1); chk("st_pc4a", if_id_pc4, 32'h50); chk("st_req", imem_req, 0);
    step(1, 0, 0, 0); chk("st_pc4b", if_id_pc4, 32'h50);
    step(1, 0, 0, 0); chk("st_pc4c", if_id_pc4, 32'h50); chk("st_instr", if_id_instr, 32'h2000_0013);
    step(0, 0, 0, 0); chk("st_rel_pc4", if_id_pc4, 32'h54); chk("st_rel_instr", if_id_instr, 32'h2000_0014);
    step(0, 0, 0, 1); chk("st_next_pc4", if_id_pc4, 32'h58);
    step(0, 1, 32'h20, 1); chk("fl_valid", if_id_valid, 0); chk("fl_addr", imem_addr, 32'h20);
    step(0, 1, 32'h100, 0); chk("dr_valid", if_id_valid, 0); chk("dr_addr", imem_addr, 32'h20);
    step(0, 0, 0, 0); chk("dr_addr2", imem_addr, 32'h20); chk("dr_valid2", if_id_valid, 0);
    step(0, 0, 0, 1); chk("dr_new_addr", imem_addr, 32'h100); chk("dr_valid3", if_id_valid, 0);
    step(0, 0, 0, 1); chk("dr_pc4", if_id_pc4, 32'h104); chk("dr_instr", if_id_instr, 32'h2000_0040);
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1); chk("wrap_pc4", if_id_pc4, 0); chk("wrap_addr", imem_addr, 0);
    jovr = 1; jaddr = 32'h10; jinstr = {6'b000010, 26'h40};
    step(0, 1, 32'h10, 1);
    step(0, 0, 0, 1); chk("j_op", opcode, 6'b000010); chk("j_pc4", if_id_pc4, 32'h14); chk("j_valid", if_id_valid, 1);
    step(0, 0, 0, 1);
    chk("j_after_valid", if_id_valid, EJ ? 0 : 1);
    chk("j_after_addr", imem_addr, EJ ? 32'h100 : 32'h18);
    step(0, 1, 32'h10, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h200, 1); chk("fj_addr", imem_addr, 32'h200); chk("fj_valid", if_id_valid, 0);
    jovr = 0;
    #2 rst = 1; #1;
    chk("mid_rst_req", imem_req, 0); chk("mid_rst_addr", imem_addr, RPC); chk("mid_rst_valid", if_id_valid, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic fast;
      fast = (i / 500) % 2 == 1;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           ($urandom_range(0, 7) == 0) ? {$urandom_range(0, 255), 2'b00} | 32'hFFFF_FC00 : {22'h0, 8'($urandom_range(0, 255)), 2'b00},
           fast ? 1'b1 : $urandom_range(0, 9) < 6);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
